// File: rtl/aes_pkg.sv
// Shared AES-128 constants, round-key FSM states and GF(2^8) doubling helper.
package aes_pkg;

    localparam logic [3:0] NR        = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Combinational AES forward S-box, one byte; shareable with the round datapath.
module aes_sbox_byte (
    input  logic [7:0] inByte,
    output logic [7:0] outByte
);

    // Entry 0x00 occupies the top byte, so entry i sits at bits [(255-i)*8 +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        outByte = SBOX_TABLE[{~inByte, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_round_key_gen.sv
// Iterative AES-128 round-key generator: one cipher key in, rounds 0..10 out.
module aes_round_key_gen
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    state_t       state;
    logic [127:0] keyReg;
    logic [3:0]   roundCnt;
    logic [7:0]   rcon;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rotW, subW, tWord;
    logic [127:0] nextKey;

    always_comb begin
        {w0, w1, w2, w3} = keyReg;
        rotW             = {w3[23:0], w3[31:24]};
    end

    for (genvar g = 0; g < 4; g++) begin : gSubWord
        aes_sbox_byte uSbox (
            .inByte  (rotW[8*g +: 8]),
            .outByte (subW[8*g +: 8])
        );
    end

    // Each new word chains off the one just produced (FIPS-197 recurrence).
    always_comb begin
        tWord          = subW ^ {rcon, 24'h0};
        nextKey[127:96] = w0 ^ tWord;
        nextKey[95:64]  = w1 ^ nextKey[127:96];
        nextKey[63:32]  = w2 ^ nextKey[95:64];
        nextKey[31:0]   = w3 ^ nextKey[63:32];
    end

    always_comb begin
        key_ready = (state == IDLE) && !flush;
        rk_valid  = (state == EMIT);
        rk_data   = keyReg;
        rk_round  = roundCnt;
        rk_last   = (state == EMIT) && (roundCnt == NR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            keyReg   <= '0;
            roundCnt <= '0;
            rcon     <= RCON_INIT;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        state    <= EMIT;
                        keyReg   <= key_in;
                        roundCnt <= '0;
                        rcon     <= RCON_INIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (roundCnt == NR) begin
                            state <= IDLE;
                        end else begin
                            keyReg   <= nextKey;
                            roundCnt <= roundCnt + 4'd1;
                            rcon     <= xtime(rcon);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Bench for aes_round_key_gen: known vectors plus a GF(2^8)-arithmetic key-expansion model.
module tb_aes_round_key_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;

    int unsigned  nChecks = 0;
    int unsigned  nFails  = 0;

    logic [127:0] modelKeys [11];
    logic [127:0] captured  [11];

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        logic [127:0] key;
        int unsigned  round;
        logic [127:0] expected;
    } vec_t;

    aes_round_key_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .key_valid (key_valid),
        .key_in    (key_in),
        .key_ready (key_ready),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_data   (rk_data),
        .rk_round  (rk_round),
        .rk_last   (rk_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // GF(2^8) arithmetic; the S-box is derived as inverse + affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sboxModel(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic expandKey(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sboxModel(temp[31:24]), sboxModel(temp[23:16]),
                        sboxModel(temp[15:8]),  sboxModel(temp[7:0])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) modelKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_keyReady"}, 128'(key_ready), 128'(1));
        check({tag, "_rkValid"},  128'(rk_valid),  128'(0));
        check({tag, "_rkData"},   rk_data,         128'h0);
        check({tag, "_rkRound"},  128'(rk_round),  128'(0));
        check({tag, "_rkLast"},   128'(rk_last),   128'(0));
    endtask

    // Hands over one key and consumes all 11 round keys, checking each against the model.
    task automatic runKey(input logic [127:0] k, input bit randReady);
        int unsigned  expRound = 0;
        int unsigned  cycles   = 0;
        logic [127:0] heldData = '0;
        logic [3:0]   heldRound = '0;
        bit           stalled  = 1'b0;
        expandKey(k);
        check("preKeyReady", 128'(key_ready), 128'(1));
        key_valid = 1'b1;
        key_in    = k;
        tick();
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        while (expRound <= 10 && cycles < 200) begin
            check("rkValid",  128'(rk_valid),  128'(1));
            check("rkData",   rk_data,         modelKeys[expRound]);
            check("rkRound",  128'(rk_round),  128'(expRound));
            check("rkLast",   128'(rk_last),   128'(expRound == 10));
            check("emitKeyReady", 128'(key_ready), 128'(0));
            if (stalled) begin
                check("stallData",  rk_data,        heldData);
                check("stallRound", 128'(rk_round), 128'(heldRound));
            end
            captured[expRound] = rk_data;
            rk_ready  = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            heldData  = rk_data;
            heldRound = rk_round;
            stalled   = !rk_ready;
            tick();
            cycles++;
            if (rk_ready) expRound++;
        end
        rk_ready = 1'b0;
        if (expRound <= 10) begin
            check("sequenceTimeout", 128'(expRound), 128'(11));
        end else begin
            check("postLastRkValid",  128'(rk_valid),  128'(0));
            check("postLastKeyReady", 128'(key_ready), 128'(1));
        end
    endtask

    task automatic advanceTo(input logic [127:0] k, input int unsigned target);
        int unsigned cycles = 0;
        key_valid = 1'b1;
        key_in    = k;
        tick();
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        while (!(rk_valid && rk_round == 4'(target)) && cycles < 50) begin
            tick();
            cycles++;
        end
        rk_ready = 1'b0;
        check("reachRound", 128'(rk_round), 128'(target));
    endtask

    initial begin
        vec_t         vecs [8];
        logic [127:0] lastKey;
        bit           haveRun;
        int           acceptCyc [$];
        bit           acc;

        vecs[0] = '{KEY_C1, 0,  KEY_C1};
        vecs[1] = '{KEY_C1, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[2] = '{KEY_A1, 0,  KEY_A1};
        vecs[3] = '{KEY_A1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[4] = '{KEY_A1, 2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[5] = '{KEY_A1, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[6] = '{KEY_A1, 9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[7] = '{KEY_A1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        rst_n     = 1'b0;
        flush     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b0;
        #1;
        checkResetOutputs("inReset");
        tick();
        tick();
        checkResetOutputs("inResetClocked");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkResetOutputs("afterReset");

        // flush at round 5 with a concurrent rk handshake
        expandKey(KEY_A1);
        advanceTo(KEY_A1, 5);
        flush    = 1'b1;
        rk_ready = 1'b1;
        key_valid = 1'b1;
        key_in    = KEY_C1;
        #1;
        check("flushKeyReady", 128'(key_ready), 128'(0));
        @(posedge clk);
        #1;
        flush     = 1'b0;
        rk_ready  = 1'b0;
        key_valid = 1'b0;
        #1;
        check("flushRkValid",  128'(rk_valid),  128'(0));
        check("flushKeyReady2", 128'(key_ready), 128'(1));
        check("flushRkLast",   128'(rk_last),   128'(0));
        check("flushNoAdvance", rk_data,        modelKeys[5]);
        tick();

        // known-answer table
        haveRun = 1'b0;
        lastKey = '0;
        for (int i = 0; i < 8; i++) begin
            if (!haveRun || vecs[i].key !== lastKey) begin
                runKey(vecs[i].key, 1'b0);
                lastKey = vecs[i].key;
                haveRun = 1'b1;
            end
            check($sformatf("vec%0d_round%0d", i, vecs[i].round), captured[vecs[i].round], vecs[i].expected);
        end

        // backpressure, twice, with random keys too
        runKey(KEY_A1, 1'b1);
        runKey({$urandom, $urandom, $urandom, $urandom}, 1'b1);

        // back-to-back with key_valid held high
        expandKey(KEY_A1);
        key_valid = 1'b1;
        key_in    = KEY_A1;
        rk_ready  = 1'b1;
        for (int c = 0; c < 40 && acceptCyc.size() < 2; c++) begin
            acc = key_valid && key_ready;
            if (rk_valid) check("b2bKeyReadyLow", 128'(key_ready), 128'(0));
            tick();
            if (acc) acceptCyc.push_back(c);
        end
        key_valid = 1'b0;
        check("b2bAccepts", 128'(acceptCyc.size()), 128'(2));
        if (acceptCyc.size() == 2)
            check("b2bPeriod", 128'(acceptCyc[1] - acceptCyc[0]), 128'(12));
        for (int r = 0; r < 11; r++) begin
            check("b2bRound", 128'(rk_round), 128'(r));
            check("b2bData",  rk_data,        modelKeys[r]);
            tick();
        end
        rk_ready = 1'b0;
        check("b2bDone", 128'(rk_valid), 128'(0));

        // asynchronous reset mid-sequence
        advanceTo(KEY_A1, 7);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("asyncReset");
        #10;
        rst_n = 1'b1;
        tick();
        checkResetOutputs("asyncRelease");
        runKey(KEY_A1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
